aud_player: RTL and testbench
=============================

// Module: aud_player
// PURPOSE
//  I2S transmitter for the codec DAC path: reads 16-bit samples from SRAM and shifts
//  them MSB-first onto DACDAT in the right-channel slot (LRC high). Left slot carries 0.
//  Sits between the top-level play FSM/SRAM mux and the codec pins.
//  Supports pause/resume/stop and variable-rate playback (skip fast, sample-repeat slow).
// PARAMETERS
//  ADDR_W  20  SRAM word-address width
//  DATA_W  16  sample width; also bits shifted per right slot
// PORTS
//  i_bclk       in   1       codec bit clock; all flops update on its falling edge
//  i_rst_n      in   1       reset, asynchronous, active-low
//  i_lrc        in   1       codec DACLRCK; 1 = right channel slot
//  i_start      in   1       begin playback from IDLE, or resume from PAUSE
//  i_pause      in   1       pause playback
//  i_stop       in   1       abort playback, return to IDLE
//  i_fast       in   1       fast mode: advance address by i_speed+1 per sample
//  i_slow       in   1       slow mode: send each sample i_speed+1 times
//  i_speed      in   3       rate factor minus one (0..7 -> x1..x8)
//  i_end_addr   in   ADDR_W  last valid sample address (inclusive)
//  i_sram_data  in   DATA_W  SRAM read data for o_address, valid combinationally
//  o_address    out  ADDR_W  SRAM read address of the current sample
//  o_dacdat     out  1       serial data to codec DACDAT
//  o_playing    out  1       1 in WAIT/SEND/HOLD
//  o_done       out  1       one-cycle pulse when the end address is passed
// BEHAVIOUR
//  Reset: state IDLE; o_address=0, o_dacdat=0, o_playing=0, o_done=0, lrc_d=0, rep=0.
//  lrc_d registers i_lrc every cycle. Right-slot edge (RE) = i_lrc & ~lrc_d at a falling edge.
//  Priority every cycle: i_stop > i_pause > i_start. i_stop in any state -> IDLE, o_address=0, o_dacdat=0, rep=0.
//  IDLE: i_start -> WAIT, o_address=0. o_dacdat=0.
//  WAIT: o_dacdat=0. On RE: latch i_sram_data into shift reg, drive bit15 on o_dacdat
//   in the same cycle (valid on 2nd BCLK rise after LRC change, I2S timing), bitcnt=14 -> SEND.
//  SEND: drive shift-reg bit bitcnt each cycle, then decrement it. Cycle after bit0 is driven -> HOLD.
//   If i_lrc falls before 16 bits complete, the remaining bits are dropped, o_dacdat=0 -> HOLD.
//  HOLD (one cycle): o_dacdat=0. Address update uses i_fast/i_slow/i_speed sampled this cycle:
//   fast (wins if both set): next = o_address + i_speed + 1.
//   slow: if rep == i_speed {rep=0; next=o_address+1} else {rep=rep+1; next=o_address}.
//   normal: next = o_address + 1; rep=0.
//   Sum computed ADDR_W+1 wide. If next > i_end_addr or carry-out set: o_done=1 for this one
//   cycle, o_address=0, rep=0 -> IDLE. Else o_address=next -> WAIT.
//  PAUSE entry from WAIT/SEND/HOLD: o_dacdat=0 immediately; an in-flight sample is discarded
//   and o_address is held, so that sample is replayed whole after resume. rep held.
//  PAUSE: i_start -> WAIT (next RE restarts the sample). i_pause while in PAUSE: stay.
//  i_start outside IDLE/PAUSE is ignored. i_end_addr=0: plays address 0 once, then done.
//  Stop or pause asserted together with RE: stop/pause wins, no bit is driven.
//  Async reset mid-SEND: o_dacdat drops to 0 immediately, all state returns to reset values.
// TESTING
//  1 Reset, start, end=2, SRAM[0..2]=16'hA55A,16'h8001,16'h7FFE -> DACDAT shows those words MSB-first in right slots only; o_done pulses once after 3rd word; o_address=0.
//  2 Normal play; check bit15 driven at the RE cycle (1st falling edge where i_lrc=1 is seen) and exactly 16 bits per slot, zero elsewhere.
//  3 i_fast=1,i_speed=3, end=10 -> addresses 0,4,8 sent, then o_done; i_fast=i_slow=1 behaves as fast.
//  4 i_slow=1,i_speed=2 -> each address sent 3 times: 0,0,0,1,1,1,...
//  5 Pause after 5 bits of addr 3, wait 4 frames, start -> DACDAT 0 while paused; addr 3 resent in full on next RE.
//  6 Stop mid-SEND -> o_dacdat=0, o_playing=0, o_address=0 same cycle; async reset mid-SEND -> outputs 0 without a clock edge.

Source files
------------

// File: rtl/aud_player_if.sv
// aud_player_if: signal bundle between the play controller/SRAM mux, the codec
// pins and the I2S transmitter aud_player.
//
// Handshake semantics: there is no valid/ready pair. Timing is set by the
// codec frame. The transmitter samples every input on the falling edge of BCLK.
// i_sram_data must be valid combinationally for the current o_address.
// i_start, i_pause and i_stop are level-sampled commands. o_done is a one-cycle
// pulse.
//
// Signals (named from the transmitter's point of view):
//   i_lrc        codec DACLRCK, 1 = right slot
//   i_start      start from IDLE / resume from PAUSE
//   i_pause      pause playback
//   i_stop       abort playback
//   i_fast       advance address by i_speed+1 per sample
//   i_slow       repeat each sample i_speed+1 times
//   i_speed      rate factor minus one
//   i_end_addr   last valid sample address (inclusive)
//   i_sram_data  SRAM read data for o_address
//   o_address    SRAM read address of the current sample
//   o_dacdat     serial data to codec DACDAT
//   o_playing    1 while in WAIT/SEND/HOLD
//   o_done       one-cycle pulse when the end address is passed
//   dbg_state    FSM state for checkers
interface aud_player_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              i_lrc;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic              i_fast;
  logic              i_slow;
  logic [2:0]        i_speed;
  logic [ADDR_W-1:0] i_end_addr;
  logic [DATA_W-1:0] i_sram_data;
  logic [ADDR_W-1:0] o_address;
  logic              o_dacdat;
  logic              o_playing;
  logic              o_done;
  logic [2:0]        dbg_state;

  modport master (
    output i_lrc, i_start, i_pause, i_stop, i_fast, i_slow, i_speed,
           i_end_addr, i_sram_data,
    input  o_address, o_dacdat, o_playing, o_done, dbg_state
  );

  modport slave (
    input  i_lrc, i_start, i_pause, i_stop, i_fast, i_slow, i_speed,
           i_end_addr, i_sram_data,
    output o_address, o_dacdat, o_playing, o_done, dbg_state
  );
endinterface

// File: rtl/aud_player.sv
// aud_player: I2S transmitter for the codec DAC path.
// It reads 16-bit samples from SRAM and shifts them MSB-first onto DACDAT in
// the right-channel slot. The left slot carries 0.
// It supports pause/resume/stop and variable-rate playback:
//   - fast mode skips addresses.
//   - slow mode repeats each sample.
//
// Ports:
//   i_bclk   codec bit clock; every flop updates on its falling edge
//   i_rst_n  asynchronous active-low reset
//   bus      aud_player_if.slave (commands, rate control, SRAM, DACDAT, status)
module aud_player #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic         i_bclk,
  input  logic         i_rst_n,
  aud_player_if.slave  bus
);

  localparam int BW = $clog2(DATA_W);
  localparam int SW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SEND  = 3'd2,
    S_HOLD  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [2:0]        rep_q, rep_d;
  logic              dacdat_q, dacdat_d;
  logic              done_q, done_d;
  logic              lrc_q;

  logic              re;
  logic              active;
  logic [SW-1:0]     next_sum;
  logic [2:0]        next_rep;
  logic              past_end;

  // Right-slot edge: LRC seen high now, low on the previous falling edge.
  assign re     = bus.i_lrc & ~lrc_q;
  assign active = (state_q == S_WAIT) || (state_q == S_SEND) || (state_q == S_HOLD);

  // Candidate next address. It is one bit wider so that a wrap past the top of
  // the address space counts as "past the end".
  always_comb begin
    next_rep = '0;
    next_sum = {1'b0, addr_q} + SW'(1);
    if (bus.i_fast) begin
      next_sum = {1'b0, addr_q} + SW'(bus.i_speed) + SW'(1);
    end else if (bus.i_slow) begin
      if (rep_q != bus.i_speed) begin
        next_sum = {1'b0, addr_q};
        next_rep = rep_q + 3'd1;
      end
    end
    past_end = next_sum[ADDR_W] || (next_sum[ADDR_W-1:0] > bus.i_end_addr);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    rep_d    = rep_q;
    dacdat_d = 1'b0;
    done_d   = 1'b0;

    if (bus.i_stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      rep_d   = '0;
    end else if (bus.i_pause) begin
      // The address is held, so the discarded in-flight sample replays whole.
      if (active) state_d = S_PAUSE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            state_d = S_WAIT;
            addr_d  = '0;
          end
        end
        S_WAIT: begin
          if (re) begin
            // The MSB goes out on the RE edge itself, giving one BCLK of I2S delay.
            shift_d  = bus.i_sram_data;
            dacdat_d = bus.i_sram_data[DATA_W-1];
            bitcnt_d = BW'(DATA_W - 2);
            state_d  = S_SEND;
          end
        end
        S_SEND: begin
          if (!bus.i_lrc) begin
            // The slot ended early, so the remaining bits are dropped.
            state_d = S_HOLD;
          end else begin
            dacdat_d = shift_q[bitcnt_q];
            if (bitcnt_q == '0) state_d = S_HOLD;
            else                bitcnt_d = bitcnt_q - BW'(1);
          end
        end
        S_HOLD: begin
          if (past_end) begin
            done_d  = 1'b1;
            addr_d  = '0;
            rep_d   = '0;
            state_d = S_IDLE;
          end else begin
            addr_d  = next_sum[ADDR_W-1:0];
            rep_d   = next_rep;
            state_d = S_WAIT;
          end
        end
        S_PAUSE: begin
          if (bus.i_start) state_d = S_WAIT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(negedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      rep_q    <= '0;
      dacdat_q <= 1'b0;
      done_q   <= 1'b0;
      lrc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      rep_q    <= rep_d;
      dacdat_q <= dacdat_d;
      done_q   <= done_d;
      lrc_q    <= bus.i_lrc;
    end
  end

  assign bus.o_address = addr_q;
  assign bus.o_dacdat  = dacdat_q;
  assign bus.o_done    = done_q;
  assign bus.o_playing = active;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_aud_player.sv
// tb_aud_player: randomized scoreboard bench for aud_player.
// A frame is 36 BCLKs: 18 left-slot cycles and 18 right-slot cycles.
// The SRAM is a small array indexed by o_address.
module tb_aud_player;
  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int FRAME = 36;
  localparam int HALF  = 18;

  logic bclk;
  logic rst_n;

  aud_player_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  aud_player #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_bclk  (bclk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [DW-1:0] mem [0:255];
  assign bus.i_sram_data = mem[bus.o_address[7:0]];

  int vectors;
  int miscompares;
  logic [DW-1:0] exp_q[$];
  int rcnt;
  int done_cnt;
  bit armed;
  logic prev_playing;
  logic [DW-1:0] rx;

  // ---------------- clock / reset / LRC ----------------
  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  // LRC changes on the rising edge, away from the DUT's sampling edge.
  initial begin
    int pos;
    pos = 0;
    bus.i_lrc = 1'b0;
    forever begin
      @(posedge bclk);
      pos = (pos + 1) % FRAME;
      bus.i_lrc = (pos >= HALF);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // rcnt counts falling edges with LRC high. Edge 1 is the right-slot edge,
  // and edges 1..16 carry bits 15..0. A slot is armed if the DUT was playing
  // during the RE cycle. It is disarmed if playing drops (pause/stop/reset).
  // The partial word is then discarded and the line must be zero.
  initial begin
    rcnt = 0;
    armed = 0;
    prev_playing = 1'b0;
    done_cnt = 0;
    rx = '0;
    forever begin
      @(negedge bclk);
      #1;
      if (bus.i_lrc) rcnt++;
      else           rcnt = 0;
      if (rcnt == 1) begin
        armed = prev_playing;
        rx = '0;
      end
      if (armed && !bus.o_playing) armed = 0;
      if (armed && rcnt >= 1 && rcnt <= 16) begin
        rx = {rx[DW-2:0], bus.o_dacdat};
        if (rcnt == 16) begin
          armed = 0;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL word_unexpected: got %h required none", rx);
          end else begin
            chk("word", 32'(rx), 32'(exp_q.pop_front()));
          end
        end
      end else begin
        chk("dacdat_idle", 32'(bus.o_dacdat), 32'd0);
      end
      if (bus.o_done === 1'b1) done_cnt++;
      prev_playing = bus.o_playing;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge bclk);
  endtask

  // Reference model: the list of samples a full run must emit.
  task automatic set_mode(input int e, input bit f, input bit s, input int sp);
    @(posedge bclk);
    bus.i_end_addr = AW'(e);
    bus.i_fast     = f;
    bus.i_slow     = s;
    bus.i_speed    = 3'(sp);
    if (f) begin
      for (int a = 0; a <= e; a += sp + 1) exp_q.push_back(mem[a]);
    end else if (s) begin
      for (int a = 0; a <= e; a++)
        for (int r = 0; r <= sp; r++) exp_q.push_back(mem[a]);
    end else begin
      for (int a = 0; a <= e; a++) exp_q.push_back(mem[a]);
    end
  endtask

  task automatic pulse_start();
    @(posedge bclk);
    bus.i_start = 1'b1;
    @(posedge bclk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    int n;
    int budget;
    d0 = done_cnt;
    n = 0;
    budget = (exp_q.size() + 3) * FRAME + 100;
    while (done_cnt == d0 && n < budget) begin
      @(posedge bclk);
      n++;
    end
    chk("done_seen", 32'(done_cnt != d0), 32'd1);
    cycles(3);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("addr_after_done", 32'(bus.o_address), 32'd0);
    chk("playing_after_done", 32'(bus.o_playing), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Waits at a rising edge until address a is being sent with n bits out.
  task automatic wait_bits(input int a, input int n);
    int k;
    k = 0;
    while (!(bus.o_address == AW'(a) && rcnt == n && armed) && k < 20 * FRAME) begin
      @(posedge bclk);
      k++;
    end
    chk("slot_reached", 32'(k < 20 * FRAME), 32'd1);
  endtask

  task automatic run(input int e, input bit f, input bit s, input int sp);
    set_mode(e, f, s, sp);
    pulse_start();
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_pause = 1'b0;
    bus.i_stop  = 1'b0;
    bus.i_fast  = 1'b0;
    bus.i_slow  = 1'b0;
    bus.i_speed = 3'd0;
    bus.i_end_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(0, 65535));
    mem[0] = 16'hA55A;
    mem[1] = 16'h8001;
    mem[2] = 16'h7FFE;

    cycles(4);
    chk("rst_address", 32'(bus.o_address), 32'd0);
    chk("rst_dacdat",  32'(bus.o_dacdat),  32'd0);
    chk("rst_playing", 32'(bus.o_playing), 32'd0);
    chk("rst_done",    32'(bus.o_done),    32'd0);
    rst_n = 1'b1;
    cycles(3);

    // Known words, then rate modes and the single-sample end case.
    run(2, 0, 0, 0);
    run(10, 1, 0, 3);
    run(10, 1, 1, 3);
    run(4, 0, 1, 2);
    run(0, 0, 0, 0);

    for (int t = 0; t < 6; t++)
      run($urandom_range(0, 10), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 7));

    // Pause after 5 bits of address 3, then resume after 4 frames.
    set_mode(6, 0, 0, 0);
    pulse_start();
    wait_bits(3, 5);
    bus.i_pause = 1'b1;
    @(posedge bclk);
    bus.i_pause = 1'b0;
    cycles(4 * FRAME);
    chk("pause_addr", 32'(bus.o_address), 32'd3);
    chk("pause_playing", 32'(bus.o_playing), 32'd0);
    pulse_start();
    wait_done();

    // Stop mid-SEND.
    set_mode(8, 0, 0, 0);
    d0 = done_cnt;
    pulse_start();
    wait_bits(2, 8);
    bus.i_stop = 1'b1;
    @(negedge bclk);
    #1;
    chk("stop_dacdat",  32'(bus.o_dacdat),  32'd0);
    chk("stop_playing", 32'(bus.o_playing), 32'd0);
    chk("stop_address", 32'(bus.o_address), 32'd0);
    @(posedge bclk);
    bus.i_stop = 1'b0;
    cycles(2 * FRAME);
    chk("stop_no_done", 32'(done_cnt - d0), 32'd0);
    chk("stop_idle", 32'(bus.o_playing), 32'd0);
    exp_q.delete();

    // Asynchronous reset mid-SEND, between clock edges.
    set_mode(8, 0, 0, 0);
    pulse_start();
    wait_bits(1, 8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dacdat",  32'(bus.o_dacdat),  32'd0);
    chk("arst_playing", 32'(bus.o_playing), 32'd0);
    chk("arst_address", 32'(bus.o_address), 32'd0);
    chk("arst_done",    32'(bus.o_done),    32'd0);
    @(posedge bclk);
    rst_n = 1'b1;
    exp_q.delete();
    cycles(2);

    run(3, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
